// File: rtl/scs8hd_a211oi_chk.sv
// Stimulus sequencer and response checker for the a211oi cell.
// Sweeps all 16 input vectors, holds each for SETTLE_CYCLES, samples Y,
// and records the mismatch count and the first failing vector.
module scs8hd_a211oi_chk #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned PASSES        = 1,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             CLK,
  input  logic             RESETB,
  input  logic             start,
  input  logic             abort,
  input  logic             y_in,
  output logic             drv_a1,
  output logic             drv_a2,
  output logic             drv_b1,
  output logic             drv_c1,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_fail_valid,
  output logic [3:0]       first_fail_vec
);

  localparam int unsigned VEC_W  = 4;
  localparam int unsigned SET_W  = 4;
  localparam int unsigned PASS_W = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [PASS_W-1:0] PASS_LAST   = PASS_W'(PASSES - 1);
  localparam logic [VEC_W-1:0]  VEC_LAST    = '1;
  localparam logic [ERR_W-1:0]  ERR_MAX     = '1;

  logic [1:0]        state_q,    state_d;
  logic [VEC_W-1:0]  vec_q,      vec_d;
  logic [SET_W-1:0]  settle_q,   settle_d;
  logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [VEC_W-1:0]  drv_q,      drv_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic              pass_q,     pass_d;
  logic [ERR_W-1:0]  err_q,      err_d;
  logic              ffv_q,      ffv_d;
  logic [VEC_W-1:0]  ffvec_q,    ffvec_d;
  logic              exp_y;

  // Golden a211oi response for the vector currently on the drives.
  assign exp_y = ~((vec_q[3] & vec_q[2]) | vec_q[1] | vec_q[0]);

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    settle_d   = settle_q;
    pass_cnt_d = pass_cnt_q;
    drv_d      = drv_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_d      = err_q;
    ffv_d      = ffv_q;
    ffvec_d    = ffvec_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // start wins over abort when not busy
        if (start) begin
          state_d    = ST_SETTLE;
          vec_d      = '0;
          settle_d   = '0;
          pass_cnt_d = '0;
          err_d      = '0;
          ffv_d      = 1'b0;
          ffvec_d    = '0;
          drv_d      = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          drv_d   = '0;
        end else if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = ST_SAMPLE;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      ST_SAMPLE: begin
        // abort suppresses the compare of this cycle
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          drv_d   = '0;
        end else begin
          if (y_in != exp_y) begin
            if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
            if (!ffv_q) begin
              ffv_d   = 1'b1;
              ffvec_d = vec_q;
            end
          end
          if (vec_q != VEC_LAST) begin
            vec_d   = vec_q + VEC_W'(1);
            drv_d   = vec_q + VEC_W'(1);
            state_d = ST_SETTLE;
          end else if (pass_cnt_q != PASS_LAST) begin
            vec_d      = '0;
            drv_d      = '0;
            pass_cnt_d = pass_cnt_q + PASS_W'(1);
            state_d    = ST_SETTLE;
          end else begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
            drv_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
        drv_d   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q    <= ST_IDLE;
      vec_q      <= '0;
      settle_q   <= '0;
      pass_cnt_q <= '0;
      drv_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      ffv_q      <= 1'b0;
      ffvec_q    <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      settle_q   <= settle_d;
      pass_cnt_q <= pass_cnt_d;
      drv_q      <= drv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      ffv_q      <= ffv_d;
      ffvec_q    <= ffvec_d;
    end
  end

  assign {drv_a1, drv_a2, drv_b1, drv_c1} = drv_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_cnt          = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_scs8hd_a211oi_chk.sv
// Directed bench for scs8hd_a211oi_chk: default, fast-settle and
// saturating multi-pass configurations driven by a behavioural cell model.
module tb_scs8hd_a211oi_chk;

  localparam int unsigned M_MODEL = 0;
  localparam int unsigned M_TIE0  = 1;
  localparam int unsigned M_TIE1  = 2;
  localparam int unsigned M_INV   = 3;
  localparam int unsigned M_FLIP9 = 4;

  typedef struct {
    int unsigned mode;
    bit          restart_mid;
    bit          with_abort;
    int          exp_cyc;
    int          exp_err;
    bit          exp_pass;
    bit          exp_ffv;
    logic [3:0]  exp_ffvec;
  } row_t;

  logic CLK;
  logic RESETB;

  int tests;
  int fails;

  function automatic logic a211oi(input logic [3:0] v);
    return ~((v[3] & v[2]) | v[1] | v[0]);
  endfunction

  // Instance A: default parameters
  logic        start_a, abort_a, y_a;
  logic        a1_a, a2_a, b1_a, c1_a, busy_a, done_a, pass_a, ffv_a;
  logic [7:0]  err_a;
  logic [3:0]  ffvec_a;
  logic [3:0]  drv_a;
  int unsigned y_mode_a;
  assign drv_a = {a1_a, a2_a, b1_a, c1_a};

  always_comb begin
    y_a = 1'b0;
    case (y_mode_a)
      M_MODEL: y_a = a211oi(drv_a);
      M_TIE0:  y_a = 1'b0;
      M_TIE1:  y_a = 1'b1;
      M_INV:   y_a = ~a211oi(drv_a);
      M_FLIP9: y_a = (drv_a == 4'd9) ? ~a211oi(drv_a) : a211oi(drv_a);
      default: y_a = 1'b0;
    endcase
  end

  scs8hd_a211oi_chk u_dut_a (
    .CLK(CLK), .RESETB(RESETB), .start(start_a), .abort(abort_a), .y_in(y_a),
    .drv_a1(a1_a), .drv_a2(a2_a), .drv_b1(b1_a), .drv_c1(c1_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
    .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a)
  );

  // Instance B: single settle cycle, model response
  logic       start_b, abort_b, y_b;
  logic       a1_b, a2_b, b1_b, c1_b, busy_b, done_b, pass_b, ffv_b;
  logic [7:0] err_b;
  logic [3:0] ffvec_b;
  assign y_b = a211oi({a1_b, a2_b, b1_b, c1_b});

  scs8hd_a211oi_chk #(.SETTLE_CYCLES(1), .PASSES(1), .ERR_W(8)) u_dut_b (
    .CLK(CLK), .RESETB(RESETB), .start(start_b), .abort(abort_b), .y_in(y_b),
    .drv_a1(a1_b), .drv_a2(a2_b), .drv_b1(b1_b), .drv_c1(c1_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
    .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b)
  );

  // Instance C: 255 passes with Y stuck high to force saturation
  logic       start_c, abort_c, y_c;
  logic       a1_c, a2_c, b1_c, c1_c, busy_c, done_c, pass_c, ffv_c;
  logic [7:0] err_c;
  logic [3:0] ffvec_c;
  assign y_c = 1'b1;

  scs8hd_a211oi_chk #(.SETTLE_CYCLES(1), .PASSES(255), .ERR_W(8)) u_dut_c (
    .CLK(CLK), .RESETB(RESETB), .start(start_c), .abort(abort_c), .y_in(y_c),
    .drv_a1(a1_c), .drv_a2(a2_c), .drv_b1(b1_c), .drv_c1(c1_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_cnt(err_c),
    .first_fail_valid(ffv_c), .first_fail_vec(ffvec_c)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Run one full sweep on instance A; checks per-cycle drives while busy.
  task automatic run_a(input int unsigned mode, input bit restart_mid,
                       input bit with_abort, output int cyc, output int drv_bad);
    int k;
    y_mode_a = mode;
    drv_bad  = 0;
    @(negedge CLK);
    start_a = 1'b1;
    abort_a = with_abort;
    @(negedge CLK);
    start_a = 1'b0;
    abort_a = 1'b0;
    k = 1;
    while (!done_a && k < 200) begin
      if (busy_a !== 1'b1 || drv_a !== 4'((k - 1) / 3)) drv_bad++;
      if (restart_mid) start_a = (k == 20);
      @(negedge CLK);
      k++;
    end
    start_a = 1'b0;
    cyc = done_a ? (k - 1) : -1;
  endtask

  row_t rows[5];

  initial begin
    int cyc;
    int bad;
    int k;
    tests = 0;
    fails = 0;

    rows[0] = '{M_MODEL, 1'b0, 1'b0, 48, 0,  1'b1, 1'b0, 4'd0};
    rows[1] = '{M_TIE0,  1'b0, 1'b0, 48, 3,  1'b0, 1'b1, 4'd0};
    rows[2] = '{M_TIE1,  1'b1, 1'b0, 48, 13, 1'b0, 1'b1, 4'd1};
    rows[3] = '{M_INV,   1'b0, 1'b1, 48, 16, 1'b0, 1'b1, 4'd0};
    rows[4] = '{M_FLIP9, 1'b0, 1'b0, 48, 1,  1'b0, 1'b1, 4'd9};

    RESETB = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; y_mode_a = M_MODEL;
    start_b = 1'b0; abort_b = 1'b0;
    start_c = 1'b0; abort_c = 1'b0;
    repeat (3) @(negedge CLK);

    chk("rst_drv",   32'(drv_a),   0);
    chk("rst_busy",  32'(busy_a),  0);
    chk("rst_done",  32'(done_a),  0);
    chk("rst_pass",  32'(pass_a),  0);
    chk("rst_err",   32'(err_a),   0);
    chk("rst_ffv",   32'(ffv_a),   0);
    chk("rst_ffvec", 32'(ffvec_a), 0);
    RESETB = 1'b1;
    @(negedge CLK);

    for (int r = 0; r < 5; r++) begin
      run_a(rows[r].mode, rows[r].restart_mid, rows[r].with_abort, cyc, bad);
      chk($sformatf("row%0d_cycles", r), 32'(cyc), 32'(rows[r].exp_cyc));
      chk($sformatf("row%0d_drives", r), 32'(bad), 0);
      chk($sformatf("row%0d_done", r),   32'(done_a), 1);
      chk($sformatf("row%0d_busy", r),   32'(busy_a), 0);
      chk($sformatf("row%0d_drv0", r),   32'(drv_a), 0);
      chk($sformatf("row%0d_err", r),    32'(err_a), 32'(rows[r].exp_err));
      chk($sformatf("row%0d_pass", r),   32'(pass_a), 32'(rows[r].exp_pass));
      chk($sformatf("row%0d_ffv", r),    32'(ffv_a), 32'(rows[r].exp_ffv));
      chk($sformatf("row%0d_ffvec", r),  32'(ffvec_a), 32'(rows[r].exp_ffvec));
    end

    // Abort during the vec 7 sample cycle with Y stuck high.
    y_mode_a = M_TIE1;
    @(negedge CLK);
    start_a = 1'b1;
    @(negedge CLK);
    start_a = 1'b0;
    for (k = 1; k < 24; k++) @(negedge CLK);
    chk("abort_pre_vec", 32'(drv_a), 7);
    abort_a = 1'b1;
    @(negedge CLK);
    abort_a = 1'b0;
    chk("abort_busy",  32'(busy_a), 0);
    chk("abort_done",  32'(done_a), 0);
    chk("abort_drv",   32'(drv_a), 0);
    chk("abort_err",   32'(err_a), 5);
    chk("abort_ffv",   32'(ffv_a), 1);
    chk("abort_ffvec", 32'(ffvec_a), 1);
    repeat (5) @(negedge CLK);
    chk("abort_hold_err",  32'(err_a), 5);
    chk("abort_hold_busy", 32'(busy_a), 0);

    run_a(M_MODEL, 1'b0, 1'b0, cyc, bad);
    chk("rerun_cycles", 32'(cyc), 48);
    chk("rerun_drives", 32'(bad), 0);
    chk("rerun_err",    32'(err_a), 0);
    chk("rerun_pass",   32'(pass_a), 1);
    chk("rerun_ffv",    32'(ffv_a), 0);

    // Asynchronous reset in the middle of a settle window.
    y_mode_a = M_TIE1;
    @(negedge CLK);
    start_a = 1'b1;
    @(negedge CLK);
    start_a = 1'b0;
    for (k = 1; k < 11; k++) @(negedge CLK);
    chk("prereset_err", 32'(err_a), 2);
    #2 RESETB = 1'b0;
    #1;
    chk("areset_busy",  32'(busy_a), 0);
    chk("areset_drv",   32'(drv_a), 0);
    chk("areset_err",   32'(err_a), 0);
    chk("areset_ffv",   32'(ffv_a), 0);
    chk("areset_ffvec", 32'(ffvec_a), 0);
    chk("areset_done",  32'(done_a), 0);
    chk("areset_pass",  32'(pass_a), 0);
    @(negedge CLK);
    RESETB = 1'b1;
    @(negedge CLK);
    chk("post_reset_busy", 32'(busy_a), 0);

    // Single settle cycle: 16 vectors x 2 cycles.
    @(negedge CLK);
    start_b = 1'b1;
    @(negedge CLK);
    start_b = 1'b0;
    k = 1;
    while (!done_b && k < 100) begin
      @(negedge CLK);
      k++;
    end
    chk("b_cycles", 32'(done_b ? k - 1 : -1), 32);
    chk("b_pass",   32'(pass_b), 1);
    chk("b_err",    32'(err_b), 0);
    chk("b_ffv",    32'(ffv_b), 0);
    chk("b_ffvec",  32'(ffvec_b), 0);
    chk("b_busy",   32'(busy_b), 0);

    // 255 passes, 13 errors each: counter must saturate.
    @(negedge CLK);
    start_c = 1'b1;
    @(negedge CLK);
    start_c = 1'b0;
    k = 1;
    while (!done_c && k < 9000) begin
      @(negedge CLK);
      k++;
    end
    chk("c_cycles", 32'(done_c ? k - 1 : -1), 8160);
    chk("c_err",    32'(err_c), 255);
    chk("c_pass",   32'(pass_c), 0);
    chk("c_ffv",    32'(ffv_c), 1);
    chk("c_ffvec",  32'(ffvec_c), 1);
    chk("c_busy",   32'(busy_c), 0);
    chk("c_drv",    32'({a1_c, a2_c, b1_c, c1_c}), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
